hit_window_integrator: RTL and testbench
========================================

# hit_window_integrator

Parametrised per-channel hit integrator for the turret's photodetector array. It counts qualified hits on each of `N_CH` detector lines over a programmable window, then thresholds each count into a `hits` vector and reports the strongest channel for aiming. It runs either one-shot (armed by a debounced trigger pulse) or in continuous back-to-back windows for target chasing. It sits between the sampled detector inputs and the LED/aim logic.

## Interface
- `N_CH`, default 9: number of detector channels.
- `ACC_W`, default 8: accumulator width per channel; accumulators saturate.
- `WIN_W`, default 11: window counter width.
- `SHOT_WIN`, default 90: one-shot window length in cycles (1..2^WIN_W-1).
- `CHASE_WIN`, default 15: chase window length in cycles (1..2^WIN_W-1).
- `SHOT_THR`, default 20: one-shot threshold; a channel hits when its count is strictly greater than this value.
- `CHASE_THR`, default 10: chase threshold, same strict-greater rule.

Ports:
- `fclk` in 1: the block's only clock; everything is on the rising edge.
- `reset` in 1: synchronous, active-low reset.
- `start` in 1: single-cycle trigger pulse from the button detector; used in one-shot mode only.
- `mode` in 1: 0 selects one-shot, 1 selects chase.
- `data_in` in N_CH: detector samples, one bit per channel.
- `data_en` in 1: sample qualifier; a channel's accumulator increments only when `data_en` and `data_in[j]` are both 1.
- `hits` out N_CH: thresholded result of the last completed window.
- `hits_valid` out 1: one-cycle pulse when `hits` and `peak_*` update.
- `busy` out 1: high while a window is being integrated.
- `peak_idx` out max(1,$clog2(N_CH)): index of the channel with the highest count in the last window.
- `peak_cnt` out ACC_W: that channel's count.

## Operation
- State machine states: IDLE, SHOT, CHASE.
- While `reset`=0 on an edge:
  - state goes to IDLE;
  - accumulators and the window counter clear;
  - every output (`hits`, `hits_valid`, `busy`, `peak_idx`, `peak_cnt`) is driven to 0.
- IDLE:
  - If `mode`=1, go to CHASE.
  - Else, if `start`=1, go to SHOT.
  - On either transition, clear the accumulators and the counter.
- SHOT:
  - Integrate for SHOT_WIN cycles, then close the window and return to IDLE.
  - If `start`=1 during SHOT, restart the window: clear accumulators and counter, no `hits_valid`.
- CHASE:
  - Integrate for CHASE_WIN cycles, close, and immediately begin the next window with no gap cycle.
  - `start` is ignored.
- Mode change mid-window (`mode` differs from the current state's mode):
  - Abort the window: clear accumulators and counter; no `hits_valid`; `hits` and `peak_*` hold.
  - Next state is CHASE if `mode`=1, else IDLE.
- Accumulation: per channel, acc[j] ← min(acc[j]+inc[j], 2^ACC_W−1), where inc[j] = `data_en` & `data_in[j]`.
- Window close, evaluated on the final cycle of the window:
  - Evaluation uses the accumulator value including that final cycle's increment (call it eff[j]).
  - `hits[j]` ← eff[j] > THR of the active mode.
  - `peak_cnt` ← max of eff over all channels.
  - `peak_idx` ← lowest index holding that maximum.
  - If all channels are 0, `peak_idx`=0 and `peak_cnt`=0.
  - Accumulators clear.
- `hits` and `peak_*` hold their values between closes.

## Timing
- SHOT: `start` is sampled high on edge t. Window cycles are t+1 … t+SHOT_WIN.
  - `busy`=1 over exactly those cycles.
  - Updated outputs and `hits_valid`=1 appear at t+SHOT_WIN+1, with `busy`=0 there.
  - A new `start` is accepted from that edge onward.
- CHASE: windows tile continuously. `hits_valid` pulses every CHASE_WIN cycles, one cycle after each window's last cycle.
  - `busy` stays 1 throughout CHASE.
- Entering CHASE takes one cycle: the IDLE→CHASE edge. The first window starts on the following cycle.
- A window of length 1 is legal; it produces one `hits_valid` per cycle in CHASE.
- `reset` low in mid-window: the window is discarded with no `hits_valid`. The first cycle with `reset`=1 behaves as IDLE.
- Result latency is 1 cycle after the final window cycle; there is no further pipelining.

## Test plan
- Reset: drive `reset`=0 with random inputs, then release. All outputs read 0. With `mode`=0 and no `start`, `hits_valid` never pulses.
- One-shot threshold at defaults: `start` pulse, then channel 0 high for 21 window cycles and channel 1 high for exactly 20; all others low. Response:
  - `hits`=9'b000000001, `peak_idx`=0, `peak_cnt`=21;
  - `hits_valid` exactly 91 cycles after `start`;
  - `busy` high for 90 cycles.
- Saturation and qualifier: ACC_W=4, all channels high for the whole window, `data_en` high every other cycle of 90. Response: `peak_cnt`=15, `peak_idx`=0 (tie goes to the lowest index), `hits` all-ones only if THR<15.
- Chase tiling: `mode`=1, channel 4 high constantly. Response:
  - `hits_valid` every 15 cycles with no gap;
  - `hits[4]`=1 with `peak_cnt`=15;
  - other channels 0.
- Abort cases:
  - Switch `mode` 1→0 mid-window: no `hits_valid`, `hits` holds, state returns to IDLE.
  - Re-`start` at window cycle 50: results arrive 91 cycles after the second `start`.
- Reset mid-SHOT at window cycle 40: no `hits_valid`, all outputs 0. A subsequent `start` yields a full 90-cycle window.

Source files
------------

// File: rtl/hit_window_integrator.sv
// hit_window_integrator: per-channel hit counter over a programmable window.
// One-shot windows are armed by a start pulse; chase mode tiles windows
// back to back. At each window close the counts are thresholded into
// `hits` and the strongest channel is reported on peak_idx/peak_cnt.
// Handshake: there is no back-pressure; hits_valid is a one-cycle strobe
// marking the cycle in which hits/peak_* take new values, and those values
// hold until the next strobe.
module hit_window_integrator #(
    parameter int N_CH      = 9,
    parameter int ACC_W     = 8,
    parameter int WIN_W     = 11,
    parameter int SHOT_WIN  = 90,
    parameter int CHASE_WIN = 15,
    parameter int SHOT_THR  = 20,
    parameter int CHASE_THR = 10,
    localparam int IDX_W    = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic             fclk,
    input  logic             reset,
    input  logic             start,
    input  logic             mode,
    input  logic [N_CH-1:0]  data_in,
    input  logic             data_en,
    output logic [N_CH-1:0]  hits,
    output logic             hits_valid,
    output logic             busy,
    output logic [IDX_W-1:0] peak_idx,
    output logic [ACC_W-1:0] peak_cnt,
    output logic [1:0]       state_dbg
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHOT  = 2'd1,
        CHASE = 2'd2
    } state_t;

    localparam logic [WIN_W-1:0] SHOT_LAST  = WIN_W'(SHOT_WIN - 1);
    localparam logic [WIN_W-1:0] CHASE_LAST = WIN_W'(CHASE_WIN - 1);
    localparam logic [ACC_W-1:0] ACC_MAX    = '1;

    state_t           state, state_nx;
    logic             clr, acc_en, close;
    logic [WIN_W-1:0] cnt;
    logic [ACC_W-1:0] acc [N_CH];
    logic [ACC_W-1:0] eff [N_CH];
    logic [N_CH-1:0]  hits_nx;
    logic [ACC_W-1:0] best_cnt;
    logic [IDX_W-1:0] best_idx;
    int               thr;

    assign busy      = (state == SHOT) || (state == CHASE);
    assign state_dbg = state;

    // State register.
    always_ff @(posedge fclk) begin
        if (!reset) state <= IDLE;
        else        state <= state_nx;
    end

    // Next state and window control: mode changes abort, start restarts a shot.
    always_comb begin
        state_nx = state;
        clr      = 1'b0;
        acc_en   = 1'b0;
        close    = 1'b0;
        case (state)
            IDLE: begin
                if (mode) begin
                    state_nx = CHASE;
                    clr      = 1'b1;
                end else if (start) begin
                    state_nx = SHOT;
                    clr      = 1'b1;
                end
            end
            SHOT: begin
                if (mode) begin
                    state_nx = CHASE;
                    clr      = 1'b1;
                end else if (start) begin
                    clr = 1'b1;
                end else begin
                    acc_en = 1'b1;
                    if (cnt == SHOT_LAST) begin
                        close    = 1'b1;
                        state_nx = IDLE;
                    end
                end
            end
            CHASE: begin
                if (!mode) begin
                    state_nx = IDLE;
                    clr      = 1'b1;
                end else begin
                    acc_en = 1'b1;
                    close  = (cnt == CHASE_LAST);
                end
            end
            default: begin
                state_nx = IDLE;
                clr      = 1'b1;
            end
        endcase
    end

    // Saturating next counts, thresholding and lowest-index peak search.
    always_comb begin
        thr      = (state == CHASE) ? CHASE_THR : SHOT_THR;
        best_cnt = '0;
        best_idx = '0;
        hits_nx  = '0;
        for (int j = 0; j < N_CH; j++) begin
            if (data_en && data_in[j] && (acc[j] != ACC_MAX)) eff[j] = acc[j] + ACC_W'(1);
            else                                              eff[j] = acc[j];
            hits_nx[j] = (int'(eff[j]) > thr);
            if (eff[j] > best_cnt) begin
                best_cnt = eff[j];
                best_idx = IDX_W'(j);
            end
        end
    end

    // Accumulators, window counter and result registers.
    always_ff @(posedge fclk) begin
        if (!reset) begin
            for (int j = 0; j < N_CH; j++) acc[j] <= '0;
            cnt        <= '0;
            hits       <= '0;
            hits_valid <= 1'b0;
            peak_idx   <= '0;
            peak_cnt   <= '0;
        end else begin
            hits_valid <= 1'b0;
            if (clr) begin
                for (int j = 0; j < N_CH; j++) acc[j] <= '0;
                cnt <= '0;
            end else if (acc_en) begin
                if (close) begin
                    for (int j = 0; j < N_CH; j++) acc[j] <= '0;
                    cnt        <= '0;
                    hits       <= hits_nx;
                    peak_idx   <= best_idx;
                    peak_cnt   <= best_cnt;
                    hits_valid <= 1'b1;
                end else begin
                    for (int j = 0; j < N_CH; j++) acc[j] <= eff[j];
                    cnt <= cnt + WIN_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_hit_window_integrator.sv
// Testbench for hit_window_integrator: a default-parameter instance plus an
// ACC_W=4 instance sharing the same inputs for saturation checks.
module tb_hit_window_integrator;

  logic       fclk = 1'b0;
  logic       reset, start, mode, data_en;
  logic [8:0] data_in;

  logic [8:0] hits;
  logic       hits_valid, busy;
  logic [3:0] peak_idx;
  logic [7:0] peak_cnt;
  logic [1:0] state_dbg;

  logic [8:0] s_hits;
  logic       s_hits_valid, s_busy;
  logic [3:0] s_peak_idx;
  logic [3:0] s_peak_cnt;
  logic [1:0] s_state_dbg;

  hit_window_integrator dut (
    .fclk(fclk), .reset(reset), .start(start), .mode(mode),
    .data_in(data_in), .data_en(data_en),
    .hits(hits), .hits_valid(hits_valid), .busy(busy),
    .peak_idx(peak_idx), .peak_cnt(peak_cnt), .state_dbg(state_dbg)
  );

  hit_window_integrator #(.ACC_W(4)) dut_s (
    .fclk(fclk), .reset(reset), .start(start), .mode(mode),
    .data_in(data_in), .data_en(data_en),
    .hits(s_hits), .hits_valid(s_hits_valid), .busy(s_busy),
    .peak_idx(s_peak_idx), .peak_cnt(s_peak_cnt), .state_dbg(s_state_dbg)
  );

  // clock / watchdog
  always #5 fclk = ~fclk;

  int n_vec  = 0;
  int n_miss = 0;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got hung run expected completion");
    n_miss++;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $fatal(1, "watchdog");
  end

  // scoreboard: {hits, peak_idx, peak_cnt}
  logic [20:0] exp_q[$];

  typedef struct {
    logic [8:0] mask_a;
    int         n_a;
    logic [8:0] mask_b;
    int         n_b;
    logic [8:0] exp_hits;
    int         exp_idx;
    int         exp_cnt;
    int         exp_s_idx;
    int         exp_s_cnt;
  } vec_t;

  vec_t vecs[6];

  // window stimulus shape: mask_a high for window cycles 1..n_a, mask_b for 1..n_b
  logic [8:0] mask_a, mask_b;
  int         n_a, n_b;
  bit         alt_en;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge fclk);
    #1;
  endtask

  task automatic drive_window(input int w);
    data_in = ((w <= n_a) ? mask_a : 9'h000) | ((w <= n_b) ? mask_b : 9'h000);
    data_en = alt_en ? w[0] : 1'b1;
  endtask

  task automatic fire_start();
    start   = 1'b1;
    data_in = 9'h000;
    data_en = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Runs the window started on the previous edge; checks latency and busy
  // duration, then pops the expected result from the scoreboard.
  task automatic wait_result(input string name, input int exp_lat, input int exp_busy);
    int          lat;
    int          busy_n;
    bit          got;
    logic [20:0] exp;
    lat    = 1;
    busy_n = 0;
    got    = 1'b0;
    for (int k = 0; k < 200 && !got; k++) begin
      if (busy) busy_n++;
      drive_window(lat);
      tick();
      lat++;
      if (hits_valid) got = 1'b1;
    end
    if (!got) begin
      n_vec++;
      n_miss++;
      $display("FAIL %s timeout: got no hits_valid expected one within 200 cycles", name);
      if (exp_q.size() > 0) void'(exp_q.pop_front());
    end else begin
      exp = exp_q.pop_front();
      check({name, " latency"}, 32'(lat), 32'(exp_lat));
      check({name, " busy_cycles"}, 32'(busy_n), 32'(exp_busy));
      check({name, " busy_at_result"}, 32'(busy), 0);
      check({name, " hits"}, 32'(hits), 32'(exp[20:12]));
      check({name, " peak_idx"}, 32'(peak_idx), 32'(exp[11:8]));
      check({name, " peak_cnt"}, 32'(peak_cnt), 32'(exp[7:0]));
    end
  endtask

  initial begin
    int hv_n;
    int gap;
    int busy_low;
    bit seen;

    vecs[0] = '{9'h001, 21, 9'h002, 20, 9'h001, 0, 21, 0, 15};
    vecs[1] = '{9'h000,  0, 9'h000,  0, 9'h000, 0,  0, 0,  0};
    vecs[2] = '{9'h100, 90, 9'h010, 90, 9'h110, 4, 90, 4, 15};
    vecs[3] = '{9'h1F0, 21, 9'h00F,  5, 9'h1F0, 4, 21, 4, 15};
    vecs[4] = '{9'h080, 30, 9'h040, 31, 9'h0C0, 6, 31, 6, 15};
    vecs[5] = '{9'h1FF, 20, 9'h000,  0, 9'h000, 0, 20, 0, 15};

    // reset with random inputs
    reset  = 1'b0;
    alt_en = 1'b0;
    mask_a = '0; mask_b = '0; n_a = 0; n_b = 0;
    for (int i = 0; i < 5; i++) begin
      start   = 1'($urandom_range(0, 1));
      mode    = 1'($urandom_range(0, 1));
      data_en = 1'($urandom_range(0, 1));
      data_in = 9'($urandom_range(0, 511));
      tick();
    end
    check("rst hits", 32'(hits), 0);
    check("rst hits_valid", 32'(hits_valid), 0);
    check("rst busy", 32'(busy), 0);
    check("rst peak_idx", 32'(peak_idx), 0);
    check("rst peak_cnt", 32'(peak_cnt), 0);
    check("rst state", 32'(state_dbg), 0);

    reset = 1'b1;
    mode  = 1'b0;
    start = 1'b0;
    hv_n  = 0;
    for (int i = 0; i < 20; i++) begin
      data_in = 9'($urandom_range(0, 511));
      data_en = 1'($urandom_range(0, 1));
      tick();
      if (hits_valid || busy) hv_n++;
    end
    check("idle no activity", 32'(hv_n), 0);

    // table-driven one-shot windows
    for (int i = 0; i < 6; i++) begin
      mask_a = vecs[i].mask_a; n_a = vecs[i].n_a;
      mask_b = vecs[i].mask_b; n_b = vecs[i].n_b;
      exp_q.push_back({vecs[i].exp_hits, 4'(vecs[i].exp_idx), 8'(vecs[i].exp_cnt)});
      fire_start();
      wait_result($sformatf("vec%0d", i), 91, 90);
      check($sformatf("vec%0d s_valid", i), 32'(s_hits_valid), 1);
      check($sformatf("vec%0d s_hits", i), 32'(s_hits), 0);
      check($sformatf("vec%0d s_idx", i), 32'(s_peak_idx), 32'(vecs[i].exp_s_idx));
      check($sformatf("vec%0d s_cnt", i), 32'(s_peak_cnt), 32'(vecs[i].exp_s_cnt));
      data_in = 9'h1FF;
      tick();
      check($sformatf("vec%0d pulse_width", i), 32'(hits_valid), 0);
      check($sformatf("vec%0d hold", i), 32'(hits), 32'(vecs[i].exp_hits));
    end

    // saturation and qualifier: all channels high, data_en on odd window cycles
    mask_a = 9'h1FF; n_a = 100000; mask_b = '0; n_b = 0; alt_en = 1'b1;
    exp_q.push_back({9'h1FF, 4'd0, 8'd45});
    fire_start();
    wait_result("sat", 91, 90);
    check("sat s_hits", 32'(s_hits), 0);
    check("sat s_idx", 32'(s_peak_idx), 0);
    check("sat s_cnt", 32'(s_peak_cnt), 15);
    alt_en = 1'b0;

    // chase tiling with channel 4 held high
    mode    = 1'b1;
    data_in = 9'h010;
    data_en = 1'b1;
    tick();
    check("chase entry state", 32'(state_dbg), 2);
    check("chase entry busy", 32'(busy), 1);
    busy_low = 0;
    for (int p = 0; p < 4; p++) begin
      gap  = 0;
      seen = 1'b0;
      for (int k = 0; k < 40 && !seen; k++) begin
        tick();
        gap++;
        if (!busy) busy_low++;
        if (hits_valid) seen = 1'b1;
      end
      check($sformatf("chase%0d period", p), 32'(gap), 15);
      check($sformatf("chase%0d hits", p), 32'(hits), 32'h010);
      check($sformatf("chase%0d peak_idx", p), 32'(peak_idx), 4);
      check($sformatf("chase%0d peak_cnt", p), 32'(peak_cnt), 15);
    end
    check("chase busy_low", 32'(busy_low), 0);

    // mode 1->0 mid-window aborts and holds the last result
    for (int k = 0; k < 5; k++) tick();
    mode    = 1'b0;
    data_in = 9'h1FF;
    tick();
    check("abort state", 32'(state_dbg), 0);
    check("abort busy", 32'(busy), 0);
    hv_n = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (hits_valid) hv_n++;
    end
    check("abort no valid", 32'(hv_n), 0);
    check("abort hits hold", 32'(hits), 32'h010);
    check("abort idx hold", 32'(peak_idx), 4);
    check("abort cnt hold", 32'(peak_cnt), 15);

    // re-start at window cycle 50
    mask_a = 9'h004; n_a = 100000; mask_b = '0; n_b = 0;
    exp_q.push_back({9'h004, 4'd2, 8'd90});
    fire_start();
    hv_n = 0;
    for (int w = 1; w <= 49; w++) begin
      drive_window(w);
      tick();
      if (hits_valid) hv_n++;
    end
    fire_start();
    check("restart no valid", 32'(hv_n + int'(hits_valid)), 0);
    wait_result("restart", 91, 90);

    // reset at window cycle 40
    mask_a = 9'h008;
    fire_start();
    for (int w = 1; w <= 39; w++) begin
      drive_window(w);
      tick();
    end
    reset = 1'b0;
    tick();
    check("midrst hits", 32'(hits), 0);
    check("midrst hits_valid", 32'(hits_valid), 0);
    check("midrst busy", 32'(busy), 0);
    check("midrst peak_idx", 32'(peak_idx), 0);
    check("midrst peak_cnt", 32'(peak_cnt), 0);
    reset = 1'b1;
    hv_n  = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (hits_valid) hv_n++;
    end
    check("midrst no valid", 32'(hv_n), 0);
    exp_q.push_back({9'h008, 4'd3, 8'd90});
    fire_start();
    wait_result("post_reset", 91, 90);

    // final report
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
